// File: rtl/pipe_hazard_unit.sv
// Hazard / forwarding controller for the 5-stage MIPS pipeline, sitting beside ID.
// Optional self-modifying-code detection is built when HAZ_SMC_EN is defined.
module pipe_hazard_unit #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned SMC_HOLD = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ID_VALID,
   input  logic [REG_AW-1:0] ID_RS,
   input  logic [REG_AW-1:0] ID_RT,
   input  logic              ID_USE_RS,
   input  logic              ID_USE_RT,
   input  logic              ID_BR,
   input  logic              ID_WREG,
   input  logic              ID_M2REG,
   input  logic              ID_WMEM,
   input  logic [REG_AW-1:0] ID_DES,
   input  logic [31:0]       EX_ADDR,
   input  logic [31:0]       IF_PC,
   input  logic [31:0]       ID_PC,
   output logic              STALL,
   output logic              FREEZE,
   output logic [1:0]        FWDA,
   output logic [1:0]        FWDB,
   output logic              SMC,
   output logic              SMC2
);

   typedef struct packed {
      logic              v;
      logic              wreg;
      logic              m2reg;
      logic              wmem;
      logic [REG_AW-1:0] des;
   } stage_t;

   localparam logic [1:0] WAIT_INIT = 2'(LOAD_LAT - 1);

   stage_t     ex_q, ex_d;
   stage_t     mem_q, mem_d;
   logic [1:0] wcnt_q, wcnt_d;

   logic freeze;
   logic hazard;
   logic smc_act;
   logic ex_rs, ex_rt, mem_rs, mem_rt;

   function automatic logic dep(stage_t st, logic use_s, logic [REG_AW-1:0] s);
      return use_s && (s != '0) && st.v && st.wreg && (st.des == s);
   endfunction

   assign ex_rs  = dep(ex_q,  ID_USE_RS, ID_RS);
   assign ex_rt  = dep(ex_q,  ID_USE_RT, ID_RT);
   assign mem_rs = dep(mem_q, ID_USE_RS, ID_RS);
   assign mem_rt = dep(mem_q, ID_USE_RT, ID_RT);

   always_comb begin
      FWDA = 2'b00;
      if (ex_rs) begin
         FWDA = 2'b01;
      end else if (mem_rs) begin
         FWDA = mem_q.m2reg ? 2'b11 : 2'b10;
      end
   end

   always_comb begin
      FWDB = 2'b00;
      if (ex_rt) begin
         FWDB = 2'b01;
      end else if (mem_rt) begin
         FWDB = mem_q.m2reg ? 2'b11 : 2'b10;
      end
   end

   // ID-resolved branches compare before the EX ALU result exists, so any EX producer stalls them.
   assign hazard = (ex_rs | ex_rt) & (ex_q.m2reg | ID_BR);
   assign freeze = (wcnt_q != '0);
   assign FREEZE = freeze;
   assign STALL  = (hazard | smc_act) & ~freeze;

   always_comb begin
      ex_d   = ex_q;
      mem_d  = mem_q;
      wcnt_d = wcnt_q;
      if (freeze) begin
         wcnt_d = wcnt_q - 2'd1;
      end else begin
         mem_d = ex_q;
         if (STALL) begin
            ex_d = '0;
         end else begin
            ex_d.v     = ID_VALID;
            ex_d.wreg  = ID_WREG;
            ex_d.m2reg = ID_M2REG;
            ex_d.wmem  = ID_WMEM;
            ex_d.des   = ID_DES;
         end
         if ((LOAD_LAT > 1) && ex_q.v && (ex_q.m2reg || ex_q.wmem)) begin
            wcnt_d = WAIT_INIT;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_q   <= '0;
         mem_q  <= '0;
         wcnt_q <= '0;
      end else begin
         ex_q   <= ex_d;
         mem_q  <= mem_d;
         wcnt_q <= wcnt_d;
      end
   end

   logic unused_mem_wmem;
   assign unused_mem_wmem = mem_q.wmem;

`ifdef HAZ_SMC_EN
   typedef enum logic {
      S_IDLE,
      S_HOLD
   } smc_state_e;

   smc_state_e state_q, state_d;
   logic [2:0] hcnt_q, hcnt_d;
   logic       ex_store;

   assign ex_store = ex_q.v & ex_q.wmem;

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      smc_act = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ex_store && ID_VALID && (EX_ADDR == ID_PC)) begin
               smc_act = 1'b1;
               state_d = S_HOLD;
               hcnt_d  = 3'(SMC_HOLD);
            end
         end
         S_HOLD: begin
            smc_act = 1'b1;
            if (!freeze) begin
               if (hcnt_q <= 3'd1) begin
                  state_d = S_IDLE;
                  hcnt_d  = '0;
               end else begin
                  hcnt_d = hcnt_q - 3'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            hcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
      end
   end

   assign SMC  = smc_act;
   assign SMC2 = ex_store & (EX_ADDR == IF_PC);
`else
   assign smc_act = 1'b0;
   assign SMC     = 1'b0;
   assign SMC2    = 1'b0;

   logic unused_smc_ins;
   assign unused_smc_ins = ^{EX_ADDR, IF_PC, ID_PC};
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: two instances (LOAD_LAT=1 and LOAD_LAT=3) checked every
// cycle against an instruction-level model, plus directed literal expectations.
module tb_pipe_hazard_unit;

   localparam int unsigned SMC_HOLD = 2;

   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       br;
      logic       wreg;
      logic       m2reg;
      logic       wmem;
      logic [4:0] des;
   } idin_t;

   typedef struct packed {
      logic       v;
      logic       wreg;
      logic       m2reg;
      logic       wmem;
      logic [4:0] des;
   } ent_t;

   typedef struct packed {
      logic       stall;
      logic       freeze;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       smc;
      logic       smc2;
      logic       hit;
   } exp_t;

   logic        clk = 1'b0;
   logic [1:0]  rst = 2'b11;
   logic        run = 1'b0;
   int          checks = 0;
   int          errors = 0;

   logic [1:0]  id_valid = '0, id_urs = '0, id_urt = '0, id_br = '0;
   logic [1:0]  id_wreg = '0, id_m2reg = '0, id_wmem = '0;
   logic [4:0]  id_rs [2];
   logic [4:0]  id_rt [2];
   logic [4:0]  id_des [2];
   logic [31:0] ex_addr [2];
   logic [31:0] if_pc [2];
   logic [31:0] id_pc [2];

   logic [1:0]  stall, freeze, smc, smc2;
   logic [1:0]  fwda [2];
   logic [1:0]  fwdb [2];

   ent_t mex [2];
   ent_t mmem [2];
   int   mwait [2];
   int   mhold [2];
   exp_t ex_e [2];

   always #5 clk = ~clk;

   initial begin
      for (int d = 0; d < 2; d++) begin
         id_rs[d] = '0; id_rt[d] = '0; id_des[d] = '0;
         ex_addr[d] = 32'hFFFF_0000; if_pc[d] = 32'h4; id_pc[d] = 32'h0;
         mex[d] = '0; mmem[d] = '0; mwait[d] = 0; mhold[d] = 0; ex_e[d] = '0;
      end
   end

   pipe_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .SMC_HOLD(SMC_HOLD)) u_lat1 (
      .CLK(clk), .RST(rst[0]), .ID_VALID(id_valid[0]), .ID_RS(id_rs[0]), .ID_RT(id_rt[0]),
      .ID_USE_RS(id_urs[0]), .ID_USE_RT(id_urt[0]), .ID_BR(id_br[0]), .ID_WREG(id_wreg[0]),
      .ID_M2REG(id_m2reg[0]), .ID_WMEM(id_wmem[0]), .ID_DES(id_des[0]), .EX_ADDR(ex_addr[0]),
      .IF_PC(if_pc[0]), .ID_PC(id_pc[0]), .STALL(stall[0]), .FREEZE(freeze[0]),
      .FWDA(fwda[0]), .FWDB(fwdb[0]), .SMC(smc[0]), .SMC2(smc2[0])
   );

   pipe_hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .SMC_HOLD(SMC_HOLD)) u_lat3 (
      .CLK(clk), .RST(rst[1]), .ID_VALID(id_valid[1]), .ID_RS(id_rs[1]), .ID_RT(id_rt[1]),
      .ID_USE_RS(id_urs[1]), .ID_USE_RT(id_urt[1]), .ID_BR(id_br[1]), .ID_WREG(id_wreg[1]),
      .ID_M2REG(id_m2reg[1]), .ID_WMEM(id_wmem[1]), .ID_DES(id_des[1]), .EX_ADDR(ex_addr[1]),
      .IF_PC(if_pc[1]), .ID_PC(id_pc[1]), .STALL(stall[1]), .FREEZE(freeze[1]),
      .FWDA(fwda[1]), .FWDB(fwdb[1]), .SMC(smc[1]), .SMC2(smc2[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // Which pipeline value an ID source needs: nearest older producer wins, $0 is never produced.
   function automatic logic [1:0] need_src(input ent_t ex, input ent_t mem, input logic use_s,
                                           input logic [4:0] s);
      if (!use_s || s == 5'd0) return 2'b00;
      if (ex.v && ex.wreg && ex.des == s) return 2'b01;
      if (mem.v && mem.wreg && mem.des == s) return mem.m2reg ? 2'b11 : 2'b10;
      return 2'b00;
   endfunction

   function automatic exp_t expect_of(input int d);
      exp_t e;
      logic ex_needed;
      e = '0;
      if (rst[d]) return e;
      e.fa   = need_src(mex[d], mmem[d], id_urs[d], id_rs[d]);
      e.fb   = need_src(mex[d], mmem[d], id_urt[d], id_rt[d]);
      e.freeze = (mwait[d] > 0);
      ex_needed = (e.fa == 2'b01) || (e.fb == 2'b01);
`ifdef HAZ_SMC_EN
      e.hit  = (mhold[d] == 0) && mex[d].v && mex[d].wmem && id_valid[d] && (ex_addr[d] == id_pc[d]);
      e.smc  = e.hit || (mhold[d] > 0);
      e.smc2 = mex[d].v && mex[d].wmem && (ex_addr[d] == if_pc[d]);
`endif
      e.stall = ((ex_needed && (mex[d].m2reg || id_br[d])) || e.smc) && !e.freeze;
      return e;
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         ex_e[d] = expect_of(d);
         if (run) begin
            chk($sformatf("u%0d_stall", d),  {31'd0, stall[d]},  {31'd0, ex_e[d].stall});
            chk($sformatf("u%0d_freeze", d), {31'd0, freeze[d]}, {31'd0, ex_e[d].freeze});
            chk($sformatf("u%0d_fwda", d),   {30'd0, fwda[d]},   {30'd0, ex_e[d].fa});
            chk($sformatf("u%0d_fwdb", d),   {30'd0, fwdb[d]},   {30'd0, ex_e[d].fb});
            chk($sformatf("u%0d_smc", d),    {31'd0, smc[d]},    {31'd0, ex_e[d].smc});
            chk($sformatf("u%0d_smc2", d),   {31'd0, smc2[d]},   {31'd0, ex_e[d].smc2});
         end
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst[d]) begin
            mex[d] = '0; mmem[d] = '0; mwait[d] = 0; mhold[d] = 0;
         end else begin
            if (ex_e[d].freeze) begin
               mwait[d] = mwait[d] - 1;
            end else begin
               mmem[d] = mex[d];
               if (ex_e[d].stall) mex[d] = '0;
               else mex[d] = '{v: id_valid[d], wreg: id_wreg[d], m2reg: id_m2reg[d],
                               wmem: id_wmem[d], des: id_des[d]};
               if (mmem[d].v && (mmem[d].m2reg || mmem[d].wmem) && lat_of(d) > 1)
                  mwait[d] = lat_of(d) - 1;
            end
            if (ex_e[d].hit) mhold[d] = SMC_HOLD;
            else if (mhold[d] > 0 && !ex_e[d].freeze) mhold[d] = mhold[d] - 1;
         end
      end
   end

   function automatic idin_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic br, input logic wreg,
                                input logic m2reg, input logic wmem, input logic [4:0] des);
      return '{v: v, rs: rs, rt: rt, urs: urs, urt: urt, br: br, wreg: wreg,
               m2reg: m2reg, wmem: wmem, des: des};
   endfunction

   function automatic idin_t LW(input logic [4:0] des, input logic [4:0] base);
      return mk(1'b1, base, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, des);
   endfunction
   function automatic idin_t ALU(input logic [4:0] des, input logic [4:0] rs, input logic [4:0] rt);
      return mk(1'b1, rs, rt, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, des);
   endfunction
   function automatic idin_t BEQ(input logic [4:0] rs, input logic [4:0] rt);
      return mk(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
   endfunction
   function automatic idin_t SW(input logic [4:0] base, input logic [4:0] rt);
      return mk(1'b1, base, rt, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
   endfunction

   // Present one instruction in ID of instance d for one cycle; returns at the sampling edge.
   task automatic cyc(input int d, input idin_t x, input logic [31:0] exa = 32'hFFFF_0000,
                      input logic [31:0] ifp = 32'h4, input logic [31:0] idp = 32'h0);
      @(posedge clk);
      #1;
      id_valid[d] = x.v;    id_rs[d] = x.rs;     id_rt[d] = x.rt;
      id_urs[d] = x.urs;    id_urt[d] = x.urt;   id_br[d] = x.br;
      id_wreg[d] = x.wreg;  id_m2reg[d] = x.m2reg; id_wmem[d] = x.wmem;
      id_des[d] = x.des;
      ex_addr[d] = exa;     if_pc[d] = ifp;      id_pc[d] = idp;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 2'b00;
      run = 1'b1;
      @(negedge clk);
      chk("rst_stall", {31'd0, stall[0]}, 32'd0);
      chk("rst_fwda",  {30'd0, fwda[0]},  32'd0);

      // load-use, LOAD_LAT=1
      cyc(0, LW(3, 1));
      chk("lu_first_stall", {31'd0, stall[0]}, 32'd0);
      cyc(0, ALU(4, 3, 5));
      chk("lu_stall", {31'd0, stall[0]}, 32'd1);
      cyc(0, ALU(4, 3, 5));
      chk("lu_release", {31'd0, stall[0]}, 32'd0);
      chk("lu_fwda11",  {30'd0, fwda[0]},  32'd3);
      chk("lu_nofreeze", {31'd0, freeze[0]}, 32'd0);

      // ALU back-to-back and with one gap
      cyc(0, ALU(2, 1, 1));
      cyc(0, ALU(6, 2, 2));
      chk("alu_fwda01", {30'd0, fwda[0]}, 32'd1);
      chk("alu_fwdb01", {30'd0, fwdb[0]}, 32'd1);
      chk("alu_nostall", {31'd0, stall[0]}, 32'd0);
      cyc(0, ALU(2, 1, 1));
      cyc(0, ALU(9, 10, 11));
      cyc(0, ALU(6, 2, 2));
      chk("gap_fwda10", {30'd0, fwda[0]}, 32'd2);
      chk("gap_fwdb10", {30'd0, fwdb[0]}, 32'd2);

      // branch after ALU producer
      cyc(0, ALU(7, 1, 1));
      cyc(0, BEQ(7, 0));
      chk("br_stall", {31'd0, stall[0]}, 32'd1);
      cyc(0, BEQ(7, 0));
      chk("br_release", {31'd0, stall[0]}, 32'd0);
      chk("br_fwda10",  {30'd0, fwda[0]},  32'd2);
      chk("br_fwdb00",  {30'd0, fwdb[0]},  32'd0);

      // $0 never matches
      cyc(0, ALU(0, 1, 1));
      cyc(0, ALU(8, 0, 0));
      chk("r0_fwda", {30'd0, fwda[0]}, 32'd0);
      chk("r0_nostall", {31'd0, stall[0]}, 32'd0);

      // branch after load
      cyc(0, LW(12, 1));
      cyc(0, BEQ(12, 13));
      chk("brld_stall", {31'd0, stall[0]}, 32'd1);
      cyc(0, BEQ(12, 13));
      chk("brld_fwda11", {30'd0, fwda[0]}, 32'd3);
      chk("brld_release", {31'd0, stall[0]}, 32'd0);

      // store hitting the ID instruction, then one hitting IF
      cyc(0, SW(1, 9));
      for (int i = 0; i < 4; i++) begin
         cyc(0, ALU(10, 1, 1), 32'h100, 32'h104, 32'h100);
`ifdef HAZ_SMC_EN
         chk($sformatf("smc_hold%0d", i), {31'd0, smc[0]}, (i < 3) ? 32'd1 : 32'd0);
         chk($sformatf("smc_stall%0d", i), {31'd0, stall[0]}, (i < 3) ? 32'd1 : 32'd0);
`else
         chk($sformatf("nosmc%0d", i), {31'd0, smc[0]}, 32'd0);
`endif
      end
      cyc(0, SW(1, 9));
      cyc(0, ALU(11, 1, 1), 32'h204, 32'h204, 32'h200);
`ifdef HAZ_SMC_EN
      chk("smc2_pulse", {31'd0, smc2[0]}, 32'd1);
`else
      chk("smc2_off", {31'd0, smc2[0]}, 32'd0);
`endif
      chk("smc2_nosmc", {31'd0, smc[0]}, 32'd0);
      cyc(0, '0, 32'h204, 32'h204, 32'h200);
      chk("smc2_end", {31'd0, smc2[0]}, 32'd0);

      // LOAD_LAT=3: freeze masks a pending load-use hazard
      cyc(1, LW(3, 1));
      cyc(1, LW(4, 1));
      chk("l3_pre", {31'd0, freeze[1]}, 32'd0);
      cyc(1, ALU(5, 4, 0));
      chk("l3_frz1", {31'd0, freeze[1]}, 32'd1);
      chk("l3_frz1_nostall", {31'd0, stall[1]}, 32'd0);
      cyc(1, ALU(5, 4, 0));
      chk("l3_frz2", {31'd0, freeze[1]}, 32'd1);
      cyc(1, ALU(5, 4, 0));
      chk("l3_frz_end", {31'd0, freeze[1]}, 32'd0);
      chk("l3_hazard_after", {31'd0, stall[1]}, 32'd1);
      cyc(1, ALU(5, 4, 0));
      chk("l3_ld2_frz", {31'd0, freeze[1]}, 32'd1);
      cyc(1, ALU(5, 4, 0));
      cyc(1, ALU(5, 4, 0));
      chk("l3_ld2_done", {31'd0, freeze[1]}, 32'd0);
      chk("l3_fwda11",   {30'd0, fwda[1]},   32'd3);

      // reset in the second freeze cycle
      cyc(1, '0);
      cyc(1, LW(3, 1));
      cyc(1, '0);
      cyc(1, '0);
      chk("rf_frz1", {31'd0, freeze[1]}, 32'd1);
      @(posedge clk);
      #1;
      chk("rf_frz2", {31'd0, freeze[1]}, 32'd1);
      rst[1] = 1'b1;
      #1;
      chk("rf_async", {31'd0, freeze[1]}, 32'd0);
      @(posedge clk);
      #1;
      rst[1] = 1'b0;
      cyc(1, '0);
      chk("rf_after", {31'd0, freeze[1]}, 32'd0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It is the successor to the combinational decode-stage controller. It tracks EX/MEM destination state internally, so it no longer needs EXDES/MEDES fed back. It adds multi-cycle data-memory latency (pipeline freeze), branch-in-ID operand stalls and a timed self-modifying-code (SMC) hold. It sits beside the ID stage and drives PC/IR write-enable, pipeline freeze and the ID operand forwarding muxes.

## Interface
- REG_AW, 5: register index width.
- LOAD_LAT, 1: data-memory cycles per load/store in MEM, legal 1..4.
- SMC_HOLD, 2: extra cycles ID is held after an SMC hit, legal 1..7.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ID_VALID  in  1  ID holds a real instruction.
- ID_RS, ID_RT  in  REG_AW  source registers.
- ID_USE_RS, ID_USE_RT  in  1  source actually read.
- ID_BR  in  1  instruction resolves in ID (beq/bne/jr).
- ID_WREG, ID_M2REG, ID_WMEM  in  1  decoded write-reg / load / store.
- ID_DES  in  REG_AW  destination register.
- EX_ADDR  in  32  EX ALU result (store address).
- IF_PC, ID_PC  in  32  PCs of IF and ID instructions.
- STALL  out  1  hold PC and IF/ID, inject bubble into EX.
- FREEZE  out  1  hold every pipeline register.
- FWDA, FWDB  out  2  00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data.
- SMC  out  1  ID instruction stale; refetch ID_PC when it falls.
- SMC2  out  1  IF instruction stale; refetch IF_PC.

## Operation
- Shadow stages EX and MEM each hold {v, wreg, m2reg, wmem, des}. A wait counter `wcnt` (2 bits) tracks memory latency. The SMC FSM uses IDLE/HOLD with a 3-bit counter.
- Update per cycle:
  - FREEZE: stages hold; wcnt decrements.
  - Else STALL: MEM←EX; EX←bubble (v=0).
  - Else: MEM←EX; EX←ID fields, with v=ID_VALID.
- When an entry with m2reg|wmem moves into MEM and LOAD_LAT>1, wcnt←LOAD_LAT-1.
- FREEZE = (wcnt≠0).
- Dependency match on source s: usage bit set, s≠0, stage v&wreg, des==s.
- Forwarding, per source:
  - EX match → 01 (highest priority).
  - Else MEM match with m2reg → 11.
  - Else MEM match → 10.
  - Else 00. Unused source → 00.
- Stall conditions (hazard):
  - Load-use: EX match with EX m2reg.
  - ID_BR with any EX match (ALU result not forwarded to ID compare).
- STALL = (hazard | SMC hold) & ~FREEZE.
- Forward select 11 is valid only when wcnt==0, which is guaranteed by FREEZE.
- Register 0 never matches. EX and MEM both matching the same register → EX wins.

## Timing
- Reset (asynchronous): stages invalid, wcnt=0, FSM IDLE. STALL, FREEZE, SMC, SMC2 = 0; FWDA = FWDB = 00.
- All outputs are combinational from shadow state plus ID inputs. No output register; zero latency.
- Load-use: exactly 1 bubble.
- Branch after ALU producer: 1 bubble.
- Branch after load: 1 bubble, then 11 forward.
- Memory op with LOAD_LAT=N: FREEZE high N-1 consecutive cycles, starting the cycle after entry to MEM.
- Simultaneous FREEZE and hazard: FREEZE only; the hazard is re-evaluated after release.
- RST mid-freeze or mid-HOLD: immediate return to reset state.

## Configuration
- HAZ_SMC_EN defined:
  - IDLE: if EX v&wmem, ID_VALID and EX_ADDR==ID_PC → SMC=1, STALL=1, move to HOLD with counter=SMC_HOLD.
  - HOLD: SMC=1 and STALL=1 (unless FREEZE). Counter decrements only when not frozen; HOLD→IDLE at 0.
  - SMC2 = EX v&wmem & (EX_ADDR==IF_PC), combinational, any state.
- HAZ_SMC_EN undefined: no FSM. SMC=SMC2=0; EX_ADDR, IF_PC and ID_PC are unused.

## Test plan
- `lw $3` then `add $4,$3,$5`, LOAD_LAT=1:
  - one STALL cycle, EX bubble.
  - next cycle FWDA=11.
  - no FREEZE.
- `add $2` then `sub $6,$2,$2`: FWDA=FWDB=01, no STALL. Same with one gap instruction: both 10.
- `add $7` then `beq $7,$0`: 1 STALL, then FWDA=10; FWDB=00 (rt=0).
- LOAD_LAT=3, `lw` followed by independent instructions:
  - FREEZE high exactly 2 cycles after the load enters MEM.
  - RST asserted in the second freeze cycle → FREEZE=0 immediately.
- HAZ_SMC_EN, SMC_HOLD=2, `sw` with EX_ADDR==ID_PC:
  - SMC and STALL high 3 cycles, then low.
  - EX_ADDR==IF_PC → SMC2 pulse 1 cycle.
- Destination $0 producer followed by a $0 consumer: FWDA=00, no STALL.
